// File: rtl/multih_phase_tracker.sv
// -----------------------------------------------------------------------------
// multih_phase_tracker
//
// Multi-h CPM phase-state tracker. Accumulates quaternary symbol decisions with
// alternating modulation indices (h0 = H0_UNITS/32, h1 = H1_UNITS/32 turns per
// unit symbol) into a 5-bit phase-state select for the downstream rotator. The
// h-index alignment is locked to an external sync marker (hSync), slips are
// counted, and carrier-phase trims (phaseAdj) are folded into the same update.
//
// Parameters:
//   H0_UNITS    phase increment per unit symbol for h index 0 (2*pi/32 units)
//   H1_UNITS    phase increment per unit symbol for h index 1 (2*pi/32 units)
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   symEn       one-cycle symbol strobe; qualifies symIn and hSync
//   sym2xEn     twice-symbol-rate strobe, passed through with one cycle delay
//   symIn       decision: 00=+1, 01=+3, 10=-1, 11=-3
//   hSync       marks the current symbol as h-index 0 (valid only with symEn)
//   adjEn       one-cycle strobe to add phaseAdj to the phase state
//   phaseAdj    phase trim, mod 32
//   clearStats  synchronous clear of symCount and slipCount
//   sel         current phase state, mod 32
//   hNext       h index applied to the next accumulated symbol
//   locked      high while tracking
//   symEnOut    symEn delayed one cycle (aligned with the new sel)
//   sym2xEnOut  sym2xEn delayed one cycle
//   symCount    symbols since the last sync, saturating at 0xFFFF
//   slipCount   h-index slips detected, saturating at 15
// -----------------------------------------------------------------------------
module multih_phase_tracker #(
    parameter int unsigned H0_UNITS = 4,
    parameter int unsigned H1_UNITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        symEn,
    input  logic        sym2xEn,
    input  logic [1:0]  symIn,
    input  logic        hSync,
    input  logic        adjEn,
    input  logic [4:0]  phaseAdj,
    input  logic        clearStats,
    output logic [4:0]  sel,
    output logic        hNext,
    output logic        locked,
    output logic        symEnOut,
    output logic        sym2xEnOut,
    output logic [15:0] symCount,
    output logic [3:0]  slipCount
);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        TRACK     = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               sync;
    logic               idx;
    logic               add_sym;
    logic               add_adj;
    logic signed [6:0]  sym_val;
    logic signed [6:0]  unit_val;
    logic signed [6:0]  delta;
    logic        [6:0]  sum;

    logic [4:0]         sel_next;
    logic               hnext_next;
    logic [15:0]        count_next;
    logic [3:0]         slip_next;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        hnext_next = hNext;
        count_next = symCount;
        slip_next  = slipCount;

        sync = symEn & hSync;
        // A sync marker forces index 0 regardless of the tracked alignment.
        idx  = hSync ? 1'b0 : hNext;

        unique case (symIn)
            2'b00:   sym_val = 7'sd1;
            2'b01:   sym_val = 7'sd3;
            2'b10:   sym_val = -7'sd1;
            default: sym_val = -7'sd3;
        endcase

        unit_val = idx ? $signed(7'(H1_UNITS)) : $signed(7'(H0_UNITS));
        delta    = sym_val * unit_val;

        add_sym = (state == TRACK) ? symEn : sync;
        add_adj = (state == TRACK) & adjEn;

        // Two's-complement wrap in 7 bits; only the low 5 bits are meaningful.
        sum = {2'b00, sel}
            + (add_sym ? $unsigned(delta) : 7'd0)
            + (add_adj ? {2'b00, phaseAdj} : 7'd0);
        sel_next = sum[4:0];

        unique case (state)
            WAIT_SYNC: begin
                if (sync) begin
                    hnext_next = 1'b1;
                    count_next = 16'd1;
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (symEn) begin
                    hnext_next = ~idx;
                    if (sync) begin
                        count_next = 16'd1;
                        if (hNext && (slipCount != 4'hF)) begin
                            slip_next = slipCount + 4'd1;
                        end
                    end else if (symCount != 16'hFFFF) begin
                        count_next = symCount + 16'd1;
                    end
                end
            end
            default: state_next = WAIT_SYNC;
        endcase

        if (clearStats) begin
            count_next = '0;
            slip_next  = '0;
        end
    end

    // Output / datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel        <= '0;
            hNext      <= 1'b0;
            symEnOut   <= 1'b0;
            sym2xEnOut <= 1'b0;
            symCount   <= '0;
            slipCount  <= '0;
        end else begin
            sel        <= sel_next;
            hNext      <= hnext_next;
            symEnOut   <= symEn;
            sym2xEnOut <= sym2xEn;
            symCount   <= count_next;
            slipCount  <= slip_next;
        end
    end

    assign locked = (state == TRACK);

endmodule

// File: tb/tb_multih_phase_tracker.sv
// -----------------------------------------------------------------------------
// tb_multih_phase_tracker
//
// Directed, table-driven bench for multih_phase_tracker. Each table row is one
// clock of stimulus together with the outputs expected just after that edge.
// Slip saturation, clear priority and asynchronous reset are exercised by
// short hand-written sequences after the table.
// -----------------------------------------------------------------------------
module tb_multih_phase_tracker;

    logic        clk;
    logic        reset;
    logic        symEn;
    logic        sym2xEn;
    logic [1:0]  symIn;
    logic        hSync;
    logic        adjEn;
    logic [4:0]  phaseAdj;
    logic        clearStats;
    logic [4:0]  sel;
    logic        hNext;
    logic        locked;
    logic        symEnOut;
    logic        sym2xEnOut;
    logic [15:0] symCount;
    logic [3:0]  slipCount;

    int n_cmp;
    int n_err;

    multih_phase_tracker #(
        .H0_UNITS (4),
        .H1_UNITS (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .symEn      (symEn),
        .sym2xEn    (sym2xEn),
        .symIn      (symIn),
        .hSync      (hSync),
        .adjEn      (adjEn),
        .phaseAdj   (phaseAdj),
        .clearStats (clearStats),
        .sel        (sel),
        .hNext      (hNext),
        .locked     (locked),
        .symEnOut   (symEnOut),
        .sym2xEnOut (sym2xEnOut),
        .symCount   (symCount),
        .slipCount  (slipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sym_en;
        logic        h_sync;
        logic [1:0]  sym_in;
        logic        adj_en;
        logic [4:0]  phase_adj;
        logic        clr;
        logic        s2x;
        logic [4:0]  e_sel;
        logic        e_hnext;
        logic        e_locked;
        logic [15:0] e_cnt;
        logic [3:0]  e_slip;
    } vec_t;

    vec_t vecs [0:16];

    task automatic check(input string name, input int idx, input logic [15:0] got,
                         input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [4:0] e_sel, input logic e_hnext,
                             input logic e_locked, input logic [15:0] e_cnt,
                             input logic [3:0] e_slip, input logic e_seo, input logic e_s2xo);
        check("sel",        idx, 16'(sel),        16'(e_sel));
        check("hNext",      idx, 16'(hNext),      16'(e_hnext));
        check("locked",     idx, 16'(locked),     16'(e_locked));
        check("symCount",   idx, symCount,        e_cnt);
        check("slipCount",  idx, 16'(slipCount),  16'(e_slip));
        check("symEnOut",   idx, 16'(symEnOut),   16'(e_seo));
        check("sym2xEnOut", idx, 16'(sym2xEnOut), 16'(e_s2xo));
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle before checks.
    task automatic apply(input logic se, input logic hs, input logic [1:0] si,
                         input logic ae, input logic [4:0] pa, input logic cl,
                         input logic s2);
        symEn      = se;
        hSync      = hs;
        symIn      = si;
        adjEn      = ae;
        phaseAdj   = pa;
        clearStats = cl;
        sym2xEn    = s2;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic se, input logic hs, input logic [1:0] si,
                                input logic ae, input logic [4:0] pa, input logic cl,
                                input logic s2, input logic [4:0] es, input logic eh,
                                input logic el, input logic [15:0] ec, input logic [3:0] esl);
        vec_t v;
        v.sym_en = se; v.h_sync = hs; v.sym_in = si; v.adj_en = ae;
        v.phase_adj = pa; v.clr = cl; v.s2x = s2;
        v.e_sel = es; v.e_hnext = eh; v.e_locked = el; v.e_cnt = ec; v.e_slip = esl;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;

        //              se hs in  ae  adj cl s2x   sel h  L  cnt slip
        vecs[0]  = mk(0, 0, 2'b00, 1, 5'd7,  0, 1,  5'd0,  0, 0, 16'd0,  4'd0); // trim ignored
        vecs[1]  = mk(1, 0, 2'b01, 0, 5'd0,  0, 0,  5'd0,  0, 0, 16'd0,  4'd0); // no sync, ignored
        vecs[2]  = mk(1, 1, 2'b00, 0, 5'd0,  0, 1,  5'd4,  1, 1, 16'd1,  4'd0); // acquire: +4
        vecs[3]  = mk(1, 0, 2'b01, 0, 5'd0,  0, 0,  5'd19, 0, 1, 16'd2,  4'd0); // h1 +15
        vecs[4]  = mk(1, 0, 2'b11, 0, 5'd0,  0, 1,  5'd7,  1, 1, 16'd3,  4'd0); // h0 -12
        vecs[5]  = mk(1, 0, 2'b00, 0, 5'd0,  0, 0,  5'd12, 0, 1, 16'd4,  4'd0); // h1 +5
        vecs[6]  = mk(1, 0, 2'b01, 0, 5'd0,  0, 0,  5'd24, 1, 1, 16'd5,  4'd0); // h0 +12
        vecs[7]  = mk(1, 0, 2'b10, 0, 5'd0,  0, 1,  5'd19, 0, 1, 16'd6,  4'd0); // h1 -5
        vecs[8]  = mk(1, 0, 2'b01, 0, 5'd0,  0, 0,  5'd31, 1, 1, 16'd7,  4'd0); // h0 +12
        vecs[9]  = mk(1, 0, 2'b00, 0, 5'd0,  0, 0,  5'd4,  0, 1, 16'd8,  4'd0); // 36 mod 32
        vecs[10] = mk(1, 0, 2'b10, 0, 5'd0,  0, 0,  5'd0,  1, 1, 16'd9,  4'd0); // h0 -4
        vecs[11] = mk(1, 0, 2'b00, 1, 5'd27, 0, 0,  5'd0,  0, 1, 16'd10, 4'd0); // 0+5+27
        vecs[12] = mk(1, 0, 2'b10, 0, 5'd0,  0, 0,  5'd28, 1, 1, 16'd11, 4'd0); // 0-4 wraps
        vecs[13] = mk(0, 0, 2'b00, 1, 5'd8,  0, 0,  5'd4,  1, 1, 16'd11, 4'd0); // trim only
        vecs[14] = mk(1, 0, 2'b00, 1, 5'd30, 0, 0,  5'd7,  0, 1, 16'd12, 4'd0); // 4+5+30
        vecs[15] = mk(1, 0, 2'b00, 0, 5'd0,  0, 1,  5'd11, 1, 1, 16'd13, 4'd0); // h0 +4
        vecs[16] = mk(1, 1, 2'b00, 0, 5'd0,  0, 0,  5'd15, 1, 1, 16'd1,  4'd1); // first slip

        reset = 1'b0;
        apply(0, 0, 2'b00, 0, 5'd0, 0, 0);
        apply(0, 0, 2'b00, 0, 5'd0, 0, 0);
        reset = 1'b1;
        check_all(-1, 5'd0, 0, 0, 16'd0, 4'd0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].sym_en, vecs[i].h_sync, vecs[i].sym_in, vecs[i].adj_en,
                  vecs[i].phase_adj, vecs[i].clr, vecs[i].s2x);
            check_all(i, vecs[i].e_sel, vecs[i].e_hnext, vecs[i].e_locked,
                      vecs[i].e_cnt, vecs[i].e_slip, vecs[i].sym_en, vecs[i].s2x);
        end

        // Fifteen more forced slips: sel keeps advancing by 4, slipCount caps at 15.
        for (int k = 1; k <= 15; k++) begin
            logic [4:0] es;
            logic [3:0] esl;
            es  = 5'((15 + 4 * k) % 32);
            esl = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            apply(1, 1, 2'b00, 0, 5'd0, 0, 0);
            check_all(100 + k, es, 1, 1, 16'd1, esl, 1, 0);
        end

        // Clear with a plain symbol: counters zero, sel 11 + 5 = 16.
        apply(1, 0, 2'b00, 0, 5'd0, 1, 0);
        check_all(200, 5'd16, 0, 1, 16'd0, 4'd0, 1, 0);

        // Clear wins over a sync restart: sel 16 + 4 = 20.
        apply(1, 1, 2'b00, 0, 5'd0, 1, 1);
        check_all(201, 5'd20, 1, 1, 16'd0, 4'd0, 1, 1);

        // Asynchronous reset mid-cycle, well away from any clock edge.
        apply(1, 0, 2'b01, 0, 5'd0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all(300, 5'd0, 0, 0, 16'd0, 4'd0, 0, 0);
        apply(0, 0, 2'b00, 0, 5'd0, 0, 0);
        reset = 1'b1;

        // After reset, only a sync symbol re-acquires.
        apply(1, 0, 2'b01, 1, 5'd3, 0, 0);
        check_all(301, 5'd0, 0, 0, 16'd0, 4'd0, 1, 0);
        apply(1, 1, 2'b11, 0, 5'd0, 0, 1);
        check_all(302, 5'd20, 1, 1, 16'd1, 4'd0, 1, 1);
        apply(0, 0, 2'b00, 0, 5'd0, 0, 0);
        check_all(303, 5'd20, 1, 1, 16'd1, 4'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multih_phase_tracker.md
# multih_phase_tracker

Multi-h CPM phase-state tracker that produces the 5-bit phase-state select (units of 2π/32) consumed by the downstream multi-h phase rotator. It accumulates quaternary symbol decisions with the alternating modulation indices h0=4/16 and h1=5/16 and keeps the h-index alignment locked to an external sync marker. It also applies carrier-phase trims and delays the symbol strobes so they arrive aligned with the select value they accompany. It sits between the symbol decision/sync logic and the rotator.

## Interface
- H0_UNITS, 4, phase increment per unit symbol for h index 0, in 2π/32 units
- H1_UNITS, 5, phase increment per unit symbol for h index 1, in 2π/32 units

- clk  input  1  system clock (100 MHz domain)
- reset  input  1  asynchronous, active-low reset
- symEn  input  1  one-cycle symbol strobe; qualifies symIn and hSync
- sym2xEn  input  1  twice-symbol-rate strobe, passed through
- symIn  input  2  decision: 00=+1, 01=+3, 10=−1, 11=−3
- hSync  input  1  marks the current symbol as h-index 0; valid only with symEn
- adjEn  input  1  one-cycle strobe to apply phaseAdj
- phaseAdj  input  5  phase trim, mod 32, added once per adjEn
- clearStats  input  1  synchronous clear of symCount and slipCount
- sel  output  5  current phase state, mod 32, drives the rotator select
- hNext  output  1  h index that applies to the next accumulated symbol
- locked  output  1  high in TRACK state
- symEnOut  output  1  symEn delayed one cycle
- sym2xEnOut  output  1  sym2xEn delayed one cycle
- symCount  output  16  symbols accumulated since the last sync; saturates at 0xFFFF
- slipCount  output  4  h-index slips detected; saturates at 15

## Operation
- States: WAIT_SYNC (reset state) and TRACK.
- WAIT_SYNC:
  - sel is held, symIn is ignored, adjEn is ignored.
  - symEn&hSync: accumulate this symbol with index 0, set hNext=1, clear symCount to 1, go to TRACK.
- TRACK, on each symEn:
  - idx = hSync ? 0 : hNext.
  - delta = a·(idx ? H1_UNITS : H0_UNITS), where a is the signed value of symIn.
  - sel <= (sel + delta) mod 32, with plain 5-bit wrap-around and no saturation.
  - hNext <= ~idx.
  - symCount increments, saturating at 0xFFFF.
- Slip: symEn&hSync in TRACK while hNext=1:
  - slipCount increments, saturating at 15.
  - The symbol uses index 0 and hNext becomes 1.
  - symCount restarts at 1.
  - State stays TRACK.
- hSync without symEn is ignored.
- adjEn in TRACK: sel <= sel + phaseAdj.
- adjEn and symEn in the same cycle: sel <= sel + delta + phaseAdj, computed mod 32 in a single update.
- clearStats: symCount and slipCount are set to 0. It takes priority over a same-cycle increment or sync restart, so both counters end at 0.
- Delta arithmetic uses a 7-bit signed intermediate (maximum |delta| = 15, with trim ≤ 46). Only the low 5 bits are kept.

## Timing
- Reset values: sel=0, hNext=0, locked=0, symEnOut=0, sym2xEnOut=0, symCount=0, slipCount=0, state=WAIT_SYNC.
- All outputs are registered.
- Latency:
  - A symEn in cycle N gives the updated sel, hNext, locked and counters in cycle N+1.
  - symEnOut is high in cycle N+1, coincident with the new sel.
- sym2xEnOut is sym2xEn delayed exactly 1 cycle.
- Back-to-back symEn on consecutive cycles is supported: each is accumulated with no dropped updates.
- If reset is asserted mid-operation, all state returns to the reset values immediately, regardless of clock. Tracking resumes only after the next symEn&hSync.

## Test plan
- Reset, then symEn+hSync with symIn=00 → next cycle sel=4, hNext=1, locked=1, symCount=1, symEnOut=1.
- Continue: symIn=01 (h1: +15) → sel=19. Then symIn=11 (h0: −12) → sel=7, hNext=1.
- Wrap-around from sel=19, hNext=0:
  - symIn=01 → sel=31.
  - symIn=00 (+5) → sel=4 (36 mod 32).
  - From sel=0 with h0, symIn=10 → sel=28.
- Slip: in TRACK with hNext=1, symEn+hSync with symIn=00 → sel advances by 4, slipCount=1, hNext=1, symCount=1. After 16 forced slips, slipCount stays at 15.
- Simultaneous events:
  - From sel=4 with h1: adjEn with phaseAdj=30 plus symEn with symIn=00 → sel=7.
  - In WAIT_SYNC: adjEn, or symEn without hSync → sel stays 0.
- clearStats together with symEn in TRACK → symCount=0 and slipCount=0 next cycle, while sel still updates. Asserting reset mid-stream → sel=0 and locked=0 asynchronously.
